// File: rtl/iter_muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: FSM state
// encodings, iteration counts, the divide-overflow result and a
// magnitude helper.
package iter_muldiv_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ACC_W     = 66;
   localparam int unsigned STEP_W    = 6;
   localparam int unsigned MUL_STEPS = 16;
   localparam int unsigned DIV_STEPS = 32;

   localparam logic [DATA_W-1:0] DIV_OVF_RESULT = 32'h8000_0000;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MUL  = 2'd1;
   localparam state_t ST_DIV  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   // Two's-complement magnitude; 0x80000000 maps to 2^31 as an unsigned value
   function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v);
      return v[DATA_W-1] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth digit recoder.
//   bits       : {b[2i+1], b[2i], b[2i-1]} of the multiplier
//   sel_zero_c : digit is 0
//   sel_2x_c   : digit magnitude is 2 (else 1 when not zero)
//   negate_c   : digit is negative
module booth_recoder (
   input  logic [2:0] bits,
   output logic       sel_zero_c,
   output logic       sel_2x_c,
   output logic       negate_c
);

   assign sel_zero_c = (bits == 3'b000) || (bits == 3'b111);
   assign sel_2x_c   = (bits == 3'b011) || (bits == 3'b100);
   // 111 is a zero digit, so it must not request negation
   assign negate_c   = bits[2] && !(bits[1] && bits[0]);

endmodule

// File: rtl/iter_muldiv.sv
// Iterative signed 32-bit multiply (radix-4 Booth, 16 steps) and divide
// (restoring, 32 steps + sign correction) unit for the execute stage.
// Ports:
//   clock, reset (async, active-high)
//   data_operandA/B : operands, sampled on a start edge
//   ctrl_MULT/DIV   : start requests (MULT wins when both high)
//   data_result     : low product word or truncated quotient
//   data_exception  : multiply overflow, divide-by-zero or divide overflow
//   data_resultRDY  : one-cycle completion pulse
// Build option: ITER_MULDIV_DIV_EN includes the divider; without it a
// divide request completes in one cycle with result 0 and exception set.
module iter_muldiv
   import iter_muldiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);

   state_t              state, state_nxt;
   logic [STEP_W-1:0]   step, step_nxt;
   logic [DATA_W-1:0]   mcand, mcand_nxt;
   logic [ACC_W-1:0]    acc, acc_nxt, acc_step;
   logic [DATA_W-1:0]   result_nxt;
   logic                exc_nxt, rdy_nxt;
   logic                sel_zero_c, sel_2x_c, negate_c;
   logic [33:0]         mag_c, sum_c;
   logic [32:0]         prod_hi_c;

`ifdef ITER_MULDIV_DIV_EN
   logic [DATA_W-1:0]   quo, quo_nxt, rem, rem_nxt, dmag, dmag_nxt;
   logic                q_neg, q_neg_nxt, d_zero, d_zero_nxt, d_ovf, d_ovf_nxt;
   logic [32:0]         shifted_c;
`endif

   booth_recoder u_booth (
      .bits       (acc[2:0]),
      .sel_zero_c (sel_zero_c),
      .sel_2x_c   (sel_2x_c),
      .negate_c   (negate_c)
   );

   // One Booth step: add digit*A into the sign-extended high part, then
   // shift the whole accumulator right by 2 arithmetically.
   always_comb begin
      if (sel_zero_c)    mag_c = '0;
      else if (sel_2x_c) mag_c = {mcand[31], mcand, 1'b0};
      else               mag_c = {{2{mcand[31]}}, mcand};
      sum_c     = {acc[65], acc[65:33]} + (negate_c ? 34'(-mag_c) : mag_c);
      acc_step  = {sum_c[33], sum_c, acc[32:2]};
      prod_hi_c = acc_step[64:32];
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt  = state;
      step_nxt   = step;
      mcand_nxt  = mcand;
      acc_nxt    = acc;
      result_nxt = data_result;
      exc_nxt    = data_exception;
      rdy_nxt    = 1'b0;
`ifdef ITER_MULDIV_DIV_EN
      quo_nxt    = quo;
      rem_nxt    = rem;
      dmag_nxt   = dmag;
      q_neg_nxt  = q_neg;
      d_zero_nxt = d_zero;
      d_ovf_nxt  = d_ovf;
      shifted_c  = {rem, quo[31]};
`endif

      case (state)
         ST_MUL: begin
            acc_nxt  = acc_step;
            step_nxt = step + STEP_W'(1);
            if (step == STEP_W'(MUL_STEPS - 1)) begin
               state_nxt  = ST_DONE;
               rdy_nxt    = 1'b1;
               result_nxt = acc_step[32:1];
               // P[63:31] must be pure sign extension for a valid 32-bit product
               exc_nxt    = !((&prod_hi_c) || !(|prod_hi_c));
            end
         end
         ST_DIV: begin
`ifdef ITER_MULDIV_DIV_EN
            if (step == STEP_W'(DIV_STEPS)) begin
               state_nxt = ST_DONE;
               rdy_nxt   = 1'b1;
               if (d_zero) begin
                  result_nxt = '0;
                  exc_nxt    = 1'b1;
               end else if (d_ovf) begin
                  result_nxt = DIV_OVF_RESULT;
                  exc_nxt    = 1'b1;
               end else begin
                  result_nxt = q_neg ? (~quo + 32'd1) : quo;
                  exc_nxt    = 1'b0;
               end
            end else begin
               // Restoring step: dividend bits shift out of quo into rem
               step_nxt = step + STEP_W'(1);
               if (shifted_c >= {1'b0, dmag}) begin
                  rem_nxt = 32'(shifted_c - {1'b0, dmag});
                  quo_nxt = {quo[30:0], 1'b1};
               end else begin
                  rem_nxt = shifted_c[31:0];
                  quo_nxt = {quo[30:0], 1'b0};
               end
            end
`else
            state_nxt  = ST_DONE;
            rdy_nxt    = 1'b1;
            result_nxt = '0;
            exc_nxt    = 1'b1;
`endif
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase

      // A start in any state restarts; an aborted operation leaves outputs untouched
      if (ctrl_MULT || ctrl_DIV) begin
         state_nxt  = ctrl_MULT ? ST_MUL : ST_DIV;
         step_nxt   = '0;
         rdy_nxt    = 1'b0;
         result_nxt = data_result;
         exc_nxt    = data_exception;
         mcand_nxt  = data_operandA;
         acc_nxt    = {33'd0, data_operandB, 1'b0};
`ifdef ITER_MULDIV_DIV_EN
         quo_nxt    = abs32(data_operandA);
         rem_nxt    = '0;
         dmag_nxt   = abs32(data_operandB);
         q_neg_nxt  = data_operandA[31] ^ data_operandB[31];
         d_zero_nxt = (data_operandB == '0);
         d_ovf_nxt  = (data_operandA == DIV_OVF_RESULT) && (&data_operandB);
`endif
      end
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         step           <= '0;
         mcand          <= '0;
         acc            <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
`ifdef ITER_MULDIV_DIV_EN
         quo            <= '0;
         rem            <= '0;
         dmag           <= '0;
         q_neg          <= 1'b0;
         d_zero         <= 1'b0;
         d_ovf          <= 1'b0;
`endif
      end else begin
         state          <= state_nxt;
         step           <= step_nxt;
         mcand          <= mcand_nxt;
         acc            <= acc_nxt;
         data_result    <= result_nxt;
         data_exception <= exc_nxt;
         data_resultRDY <= rdy_nxt;
`ifdef ITER_MULDIV_DIV_EN
         quo            <= quo_nxt;
         rem            <= rem_nxt;
         dmag           <= dmag_nxt;
         q_neg          <= q_neg_nxt;
         d_zero         <= d_zero_nxt;
         d_ovf          <= d_ovf_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_iter_muldiv.sv
// Scoreboard bench for iter_muldiv: expected result, exception and
// completion cycle are queued at issue time and checked on each RDY pulse.
module tb_iter_muldiv;

   logic        clock;
   logic        reset;
   logic [31:0] data_operandA, data_operandB;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   iter_muldiv dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference behaviour: result, exception and RDY latency in cycles
   function automatic void model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e, output int lat);
      logic signed [63:0] sa, sb, p;
      if (m) begin
         sa  = {{32{a[31]}}, a};
         sb  = {{32{b[31]}}, b};
         p   = sa * sb;
         r   = p[31:0];
         e   = !((&p[63:31]) || !(|p[63:31]));
         lat = 16;
      end else begin
`ifdef ITER_MULDIV_DIV_EN
         lat = 33;
         if (b == 32'd0) begin
            r = 32'd0; e = 1'b1;
         end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000; e = 1'b1;
         end else begin
            r = 32'($signed(a) / $signed(b)); e = 1'b0;
         end
`else
         lat = 1;
         r   = 32'd0;
         e   = 1'b1;
`endif
      end
   endfunction

   // Drive a one-cycle start from a negedge; optionally queue its expectation
   task automatic issue(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input bit push);
      exp_t        e;
      logic [31:0] r;
      logic        x;
      int          lat;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      model(m, a, b, r, x, lat);
      if (push) begin
         e.res = r;
         e.exc = x;
         e.cyc = cyc + 1 + lat;
         q.push_back(e);
      end
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clock);
      if (q.size() != 0) begin
         check("drain_timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
   endtask

   // Output monitor
   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         if (data_resultRDY) begin
            if (q.size() == 0) check("spurious_rdy", 64'(data_resultRDY), 64'd0);
            else begin
               e = q.pop_front();
               check("rdy_cycle", 64'(cyc), 64'(e.cyc));
               check("result", 64'(data_result), 64'(e.res));
               check("exception", 64'(data_exception), 64'(e.exc));
            end
         end else if (q.size() != 0 && cyc > q[0].cyc) begin
            check("rdy_missing", 64'(cyc), 64'(q[0].cyc));
            void'(q.pop_front());
         end
      end
   end

   initial begin
      logic        m;
      logic [31:0] a, b;
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(negedge clock);
      check("reset_result", 64'(data_result), 64'd0);
      check("reset_exception", 64'(data_exception), 64'd0);
      check("reset_rdy", 64'(data_resultRDY), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      // Directed vectors
      issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1);        drain();
      issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1); drain();
      issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);         drain();
      issue(1'b0, 1'b1, 32'd5, 32'd0, 1'b1);                 drain();
      issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); drain();
      issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); drain();

      // Multiply aborted at N+5 by a divide: only the divide completes
      issue(1'b1, 1'b0, 32'd9, 32'd9, 1'b0);
      repeat (4) @(negedge clock);
      issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b1);
      drain();

      // Simultaneous starts: multiply wins
      issue(1'b1, 1'b1, 32'd3, 32'd4, 1'b1); drain();

      // Back-to-back: new start issued during the RDY cycle
      issue(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd11, 1'b1);
      repeat (16) @(negedge clock);
      issue(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFFD, 1'b1);
      drain();

      // Asynchronous reset during a divide
`ifdef ITER_MULDIV_DIV_EN
      issue(1'b0, 1'b1, 32'd123456, 32'd7, 1'b0);
`else
      issue(1'b0, 1'b1, 32'd123456, 32'd7, 1'b1);
`endif
      repeat (9) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("async_rst_result", 64'(data_result), 64'd0);
      check("async_rst_exception", 64'(data_exception), 64'd0);
      check("async_rst_rdy", 64'(data_resultRDY), 64'd0);
      q.delete();
      @(negedge clock);
      reset = 1'b0;
      repeat (45) @(negedge clock);
      issue(1'b1, 1'b0, 32'd6, 32'd7, 1'b1); drain();

      // Random operations, half with small operands to hit zero/negative divisors
      for (int i = 0; i < 12; i++) begin
         m = 1'($urandom_range(0, 1));
         a = $urandom;
         b = (i % 2 == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
         if (i % 3 == 0) a = 32'($urandom_range(0, 2000)) - 32'd1000;
         issue(m, !m, a, b, 1'b1);
         drain();
      end

      repeat (5) @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/iter_muldiv.md
# iter_muldiv

Iterative signed 32-bit multiply/divide unit feeding the execute stage of the 5-stage pipelined processor. The execute stage issues a one-cycle start request with both operands, holds the pipeline, and resumes on the single-cycle `data_resultRDY` pulse. The result and exception flag are then captured into the X/M latch. Multiply uses radix-4 Booth recoding. Divide uses a shift/subtract loop with sign correction.

## Interface
Parameters:
- none. Operand and result width is fixed at 32.

Ports:
- `clock`  in  1  master clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; returns the unit to IDLE immediately.
- `data_operandA`  in  32  multiplicand / dividend (signed); sampled only on start.
- `data_operandB`  in  32  multiplier / divisor (signed); sampled only on start.
- `ctrl_MULT`  in  1  start a multiply; sampled at the rising edge.
- `ctrl_DIV`  in  1  start a divide; sampled at the rising edge.
- `data_result`  out  32  low 32 bits of the product, or the quotient truncated toward zero.
- `data_exception`  out  1  multiply overflow, divide-by-zero, or divide overflow.
- `data_resultRDY`  out  1  one-cycle pulse; `data_result` and `data_exception` are valid during it.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Start (any state): on a rising edge with `ctrl_MULT` or `ctrl_DIV` high:
  - latch both operands and clear the step counter;
  - go to MUL or DIV;
  - an in-flight operation is aborted silently and no RDY is produced for it.
- Simultaneous start: `ctrl_MULT` and `ctrl_DIV` both high starts a multiply (MULT wins).
- MUL:
  - 66-bit accumulator {P[63:0], q-1}; each step consumes 2 multiplier bits.
  - Booth digit in {-2,-1,0,+1,+2}; the add is 34-bit sign-extended, followed by an arithmetic shift right by 2.
  - 16 steps, then DONE.
- MUL exception: set if P[63:31] are not all equal. `data_result` = P[31:0] regardless.
- DIV:
  - operands are converted to magnitudes and the sign flags are recorded;
  - 32 restoring shift/subtract steps;
  - then one correction step that negates the quotient if the signs differ, then DONE.
- Divide by zero: B = 0 gives result 0 and exception 1. The full iteration count is still consumed, so latency is uniform.
- Divide overflow: A = 0x80000000, B = 0xFFFFFFFF gives result 0x80000000 and exception 1.
- The remainder is not output.
- DONE: `data_resultRDY` = 1 for exactly one cycle, then IDLE.
- Output holding: `data_result` and `data_exception` keep their value until the next DONE or reset. They are not cleared by a new start.
- Reset, including mid-operation: state IDLE, `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.

## Timing
- Start sampled at edge N.
- Multiply: iterations at edges N+1..N+16; DONE entered at edge N+16; `data_resultRDY` high from N+16 to N+17.
- Divide: iterations at edges N+1..N+32, correction at edge N+33; `data_resultRDY` high from N+33 to N+34.
- A start sampled at the same edge that leaves DONE is accepted. Back-to-back operations therefore need no idle cycle.
- A start held high for several cycles restarts on every edge. The caller pulses it once; the execute stage gates it with its own in-progress flag.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `ITER_MULDIV_DIV_EN` defined: the full divider is built as specified above.
- `ITER_MULDIV_DIV_EN` undefined:
  - the divider datapath is removed;
  - `ctrl_DIV` goes directly to DONE at edge N+1 with `data_result` = 0 and `data_exception` = 1;
  - multiply is unchanged.

## Structure
- Package `iter_muldiv_pkg` holds:
  - the state enum (IDLE, MUL, DIV, DONE);
  - `MUL_STEPS` = 16 and `DIV_STEPS` = 32;
  - the `DIV_OVF_RESULT` constant 0x80000000.
- One sub-module, `booth_recoder`, is combinational:
  - input: 3 multiplier bits;
  - outputs: select-zero, select-2x, negate.

## Test plan
- Multiply: A = 7, B = -3 (0xFFFFFFFD), pulse `ctrl_MULT` at N → RDY only in cycle N+16..N+17; result 0xFFFFFFEB; exception 0.
- Multiply overflow: A = 0x00010000, B = 0x00010000 → RDY at N+16; result 0x00000000; exception 1.
- Divide: A = -7, B = 2 → RDY at N+33; result 0xFFFFFFFD; exception 0. Then A = 5, B = 0 → result 0; exception 1.
- Abort/priority:
  - multiply started at N, then `ctrl_DIV` with A = 100, B = 7 at N+5 → a single RDY at N+38 with result 14;
  - both starts high together with A = 3, B = 4 → a multiply result of 12 at +16.
- Reset: assert `reset` asynchronously mid-divide at N+10 → all outputs 0 immediately; no RDY afterwards; a new multiply 6×7 gives 42.
- Divide removed: build without `ITER_MULDIV_DIV_EN`, pulse `ctrl_DIV` at N → RDY at N+1; result 0; exception 1.
